issue_scoreboard: RTL and testbench

- Issue stage directly upstream of the register file.
- Buffers one decoded instruction and tracks a per-register busy bit.
- Issues the instruction to the ALU or load/store unit once there is no RAW/WAW hazard and the target unit can accept it.
- Drives the register file read request; its exe_* sideband arrives in the same cycle as the register file's exe_rs1/exe_rs2 operands.

---
 rtl/issue_scoreboard_pkg.sv | 26 ++
 rtl/issue_scoreboard_busy_table.sv | 39 +++
 rtl/issue_scoreboard.sv | 111 +++++++++++
 tb/tb_issue_scoreboard.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_scoreboard_pkg.sv
// rtl/issue_scoreboard_pkg.sv - shared constants, instruction record and unit-stall helper for the issue stage
package issue_scoreboard_pkg;

  localparam int DEFAULT_REG_WIDTH  = 5;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_OP_WIDTH   = 6;

  localparam logic DEST_ALU = 1'b0;
  localparam logic DEST_LS  = 1'b1;

  typedef struct packed {
    logic                          dest;
    logic [DEFAULT_REG_WIDTH-1:0]  rs1;
    logic [DEFAULT_REG_WIDTH-1:0]  rs2;
    logic [DEFAULT_REG_WIDTH-1:0]  rd;
    logic                          rd_en;
    logic [DEFAULT_OP_WIDTH-1:0]   op;
    logic [DEFAULT_DATA_WIDTH-1:0] imm;
  } instr_t;

  function automatic logic unit_stall(input logic dest, input logic alu_busy,
                                      input logic ls_busy);
    return (dest == DEST_LS) ? ls_busy : alu_busy;
  endfunction

endpackage

// File: rtl/issue_scoreboard_busy_table.sv
// rtl/issue_scoreboard_busy_table.sv - per-register busy bits with set/clear update and three hazard read ports
module issue_scoreboard_busy_table
  import issue_scoreboard_pkg::*;
#(
  parameter int REG_WIDTH = DEFAULT_REG_WIDTH,
  parameter int REG_SIZE  = 2**REG_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_en,
  input  logic [REG_WIDTH-1:0] set_idx,
  input  logic                 clr_en,
  input  logic [REG_WIDTH-1:0] clr_idx,
  input  logic [REG_WIDTH-1:0] rd_idx_a,
  input  logic [REG_WIDTH-1:0] rd_idx_b,
  input  logic [REG_WIDTH-1:0] rd_idx_c,
  output logic                 busy_a,
  output logic                 busy_b,
  output logic                 busy_c
);

  logic [REG_SIZE-1:0] busy;

  // Set is applied after clear so a same-index collision leaves the bit set;
  // index 0 is never written, keeping x0 permanently free.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (clr_en && (clr_idx != '0)) busy[clr_idx] <= 1'b0;
      if (set_en && (set_idx != '0)) busy[set_idx] <= 1'b1;
    end
  end

  assign busy_a = busy[rd_idx_a];
  assign busy_b = busy[rd_idx_b];
  assign busy_c = busy[rd_idx_c];

endmodule

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - single-entry issue buffer with RAW/WAW scoreboard ahead of the register file
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int REG_WIDTH  = DEFAULT_REG_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int OP_WIDTH   = DEFAULT_OP_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dec_valid,
  output logic                  dec_ready,
  input  logic                  dec_dest,
  input  logic [REG_WIDTH-1:0]  dec_rs1,
  input  logic [REG_WIDTH-1:0]  dec_rs2,
  input  logic [REG_WIDTH-1:0]  dec_rd,
  input  logic                  dec_rd_en,
  input  logic [OP_WIDTH-1:0]   dec_op,
  input  logic [DATA_WIDTH-1:0] dec_imm,
  input  logic                  alu_busy,
  input  logic                  ls_busy,
  output logic                  sb_valid,
  output logic                  sb_dest,
  output logic [REG_WIDTH-1:0]  sb_rs1,
  output logic [REG_WIDTH-1:0]  sb_rs2,
  output logic                  exe_valid,
  output logic                  exe_dest,
  output logic [OP_WIDTH-1:0]   exe_op,
  output logic [DATA_WIDTH-1:0] exe_imm,
  output logic [REG_WIDTH-1:0]  exe_rd,
  output logic                  exe_rd_en,
  input  logic                  wb_valid,
  input  logic [REG_WIDTH-1:0]  wb_rd
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  logic [0:0] state;
  instr_t     ibuf;
  instr_t     exe_q;
  instr_t     dec_ins;
  logic       busy_rs1, busy_rs2, busy_rd;
  logic       hazard;
  logic       accept;
  logic       unused_exe_rs;

  assign dec_ins = '{dest: dec_dest, rs1: dec_rs1, rs2: dec_rs2, rd: dec_rd,
                     rd_en: dec_rd_en, op: dec_op, imm: dec_imm};

  issue_scoreboard_busy_table #(
    .REG_WIDTH (REG_WIDTH)
  ) u_busy (
    .clk      (clk),
    .rst      (rst),
    .set_en   (sb_valid & ibuf.rd_en),
    .set_idx  (ibuf.rd),
    .clr_en   (wb_valid),
    .clr_idx  (wb_rd),
    .rd_idx_a (ibuf.rs1),
    .rd_idx_b (ibuf.rs2),
    .rd_idx_c (ibuf.rd),
    .busy_a   (busy_rs1),
    .busy_b   (busy_rs2),
    .busy_c   (busy_rd)
  );

  // Same-cycle writeback is deliberately not bypassed: the register file
  // reads and writes on one edge, so a cleared register issues next cycle.
  assign hazard    = busy_rs1 | busy_rs2 | (ibuf.rd_en & busy_rd);
  assign sb_valid  = (state == ST_HOLD) & ~hazard
                     & ~unit_stall(ibuf.dest, alu_busy, ls_busy);
  assign dec_ready = (state == ST_EMPTY) | sb_valid;
  assign accept    = dec_valid & dec_ready;

  assign sb_dest = ibuf.dest;
  assign sb_rs1  = ibuf.rs1;
  assign sb_rs2  = ibuf.rs2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
      ibuf  <= '0;
    end else if (accept) begin
      state <= ST_HOLD;
      ibuf  <= dec_ins;
    end else if (sb_valid) begin
      state <= ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exe_valid <= 1'b0;
      exe_q     <= '0;
    end else begin
      exe_valid <= sb_valid;
      if (sb_valid) exe_q <= ibuf;
    end
  end

  assign exe_dest  = exe_q.dest;
  assign exe_op    = exe_q.op;
  assign exe_imm   = exe_q.imm;
  assign exe_rd    = exe_q.rd;
  assign exe_rd_en = exe_q.rd_en;

  // Source indices travel with the record but are consumed by the register file, not execute.
  assign unused_exe_rs = ^{exe_q.rs1, exe_q.rs2};

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - directed and randomized self-checking bench for issue_scoreboard
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid, dec_ready, dec_dest, dec_rd_en;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic [5:0]  dec_op;
  logic [31:0] dec_imm;
  logic        alu_busy, ls_busy;
  logic        sb_valid, sb_dest;
  logic [4:0]  sb_rs1, sb_rs2;
  logic        exe_valid, exe_dest, exe_rd_en;
  logic [5:0]  exe_op;
  logic [31:0] exe_imm;
  logic [4:0]  exe_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  issue_scoreboard dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_dest(dec_dest),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_rd_en(dec_rd_en),
    .dec_op(dec_op), .dec_imm(dec_imm),
    .alu_busy(alu_busy), .ls_busy(ls_busy),
    .sb_valid(sb_valid), .sb_dest(sb_dest), .sb_rs1(sb_rs1), .sb_rs2(sb_rs2),
    .exe_valid(exe_valid), .exe_dest(exe_dest), .exe_op(exe_op), .exe_imm(exe_imm),
    .exe_rd(exe_rd), .exe_rd_en(exe_rd_en),
    .wb_valid(wb_valid), .wb_rd(wb_rd)
  );

  // Reference model: a queue of at most one pending instruction and a set of busy registers.
  typedef struct {
    bit          dest;
    int          rs1, rs2, rd;
    bit          rd_en;
    int          op;
    logic [31:0] imm;
  } m_ins_t;

  m_ins_t m_pending[$];
  m_ins_t m_last;       // fields most recently loaded into the buffer
  m_ins_t m_exe;
  bit     m_exe_valid;
  bit     m_busy[32];

  function automatic bit m_can_issue();
    m_ins_t p;
    bit stalled;
    if (m_pending.size() == 0) return 1'b0;
    p = m_pending[0];
    if (m_busy[p.rs1] || m_busy[p.rs2] || (p.rd_en && m_busy[p.rd])) return 1'b0;
    stalled = p.dest ? ls_busy : alu_busy;
    return !stalled;
  endfunction

  function automatic bit m_ready();
    return (m_pending.size() == 0) || m_can_issue();
  endfunction

  task automatic m_clear();
    m_pending.delete();
    m_last = '{default: 0};
    m_exe = '{default: 0};
    m_exe_valid = 1'b0;
    foreach (m_busy[i]) m_busy[i] = 1'b0;
  endtask

  task automatic m_tick();
    bit issue, acc;
    m_ins_t n;
    if (rst) begin
      m_clear();
      return;
    end
    issue = m_can_issue();
    acc   = dec_valid && m_ready();
    m_exe_valid = issue;
    if (issue) begin
      m_exe = m_pending.pop_front();
      if (m_exe.rd_en && m_exe.rd != 0) m_busy[m_exe.rd] = 1'b1;
    end
    if (wb_valid && wb_rd != 0 && !(issue && m_exe.rd_en && m_exe.rd == int'(wb_rd)))
      m_busy[wb_rd] = 1'b0;
    if (acc) begin
      n = '{dest: dec_dest, rs1: dec_rs1, rs2: dec_rs2, rd: dec_rd,
            rd_en: dec_rd_en, op: dec_op, imm: dec_imm};
      m_pending.push_back(n);
      m_last = n;
    end
  endtask

  task automatic step();
    @(posedge clk);
    m_tick();
    #1;
  endtask

  task automatic idle_inputs();
    dec_valid = 0; dec_dest = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
    dec_rd_en = 0; dec_op = 0; dec_imm = 0;
    alu_busy = 0; ls_busy = 0; wb_valid = 0; wb_rd = 0;
  endtask

  task automatic offer(input bit dest, input int rs1, input int rs2, input int rd,
                       input bit rd_en, input int op, input logic [31:0] imm);
    dec_valid = 1; dec_dest = dest; dec_rs1 = 5'(rs1); dec_rs2 = 5'(rs2);
    dec_rd = 5'(rd); dec_rd_en = rd_en; dec_op = 6'(op); dec_imm = imm;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors++; if (sb_valid !== 1'b0) begin errors++; $display("FAIL reset_sb_valid got %0b want 0", sb_valid); end
    vectors++; if (exe_valid !== 1'b0) begin errors++; $display("FAIL reset_exe_valid got %0b want 0", exe_valid); end
    vectors++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL reset_dec_ready got %0b want 1", dec_ready); end
    vectors++; if ({sb_rs1, sb_rs2} !== 10'd0) begin errors++; $display("FAIL reset_sb_rs got %0d/%0d want 0/0", sb_rs1, sb_rs2); end
    vectors++; if ({exe_dest, exe_op, exe_imm, exe_rd, exe_rd_en} !== 45'd0) begin errors++; $display("FAIL reset_exe_fields got rd=%0d op=%0d imm=%0h want 0", exe_rd, exe_op, exe_imm); end
    vectors++; if (dut.u_busy.busy !== 32'd0) begin errors++; $display("FAIL reset_busy got %h want 0", dut.u_busy.busy); end
  endtask

  task automatic test_basic_alu();
    do_reset();
    offer(0, 1, 2, 3, 1, 9, 32'h1234);
    #1;
    vectors++; if (sb_valid !== 1'b0) begin errors++; $display("FAIL basic_accept_cycle_sb_valid got %0b want 0", sb_valid); end
    step();
    dec_valid = 0;
    #1;
    vectors++; if (sb_valid !== 1'b1) begin errors++; $display("FAIL basic_sb_valid got %0b want 1", sb_valid); end
    vectors++; if (sb_rs1 !== 5'd1 || sb_rs2 !== 5'd2) begin errors++; $display("FAIL basic_sb_rs got %0d/%0d want 1/2", sb_rs1, sb_rs2); end
    step();
    #1;
    vectors++; if (exe_valid !== 1'b1 || exe_rd !== 5'd3) begin errors++; $display("FAIL basic_exe got valid=%0b rd=%0d want 1/3", exe_valid, exe_rd); end
    vectors++; if (dut.u_busy.busy[3] !== 1'b1) begin errors++; $display("FAIL basic_busy3 got %0b want 1", dut.u_busy.busy[3]); end
    step();
    #1;
    vectors++; if (exe_valid !== 1'b0) begin errors++; $display("FAIL basic_exe_pulse got %0b want 0", exe_valid); end
  endtask

  task automatic test_raw();
    do_reset();
    offer(0, 1, 2, 5, 1, 1, 32'h0);
    step();
    offer(0, 5, 0, 6, 1, 2, 32'h55);
    step();
    dec_valid = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++; if (sb_valid !== 1'b0 || dec_ready !== 1'b0) begin errors++; $display("FAIL raw_stall_%0d got sb_valid=%0b dec_ready=%0b want 0/0", c, sb_valid, dec_ready); end
      step();
    end
    wb_valid = 1; wb_rd = 5;
    #1;
    vectors++; if (sb_valid !== 1'b0) begin errors++; $display("FAIL raw_wb_cycle got %0b want 0", sb_valid); end
    step();
    wb_valid = 0;
    #1;
    vectors++; if (sb_valid !== 1'b1) begin errors++; $display("FAIL raw_after_wb got %0b want 1", sb_valid); end
    step();
    #1;
    vectors++; if (exe_valid !== 1'b1 || exe_rd !== 5'd6 || exe_imm !== 32'h55) begin errors++; $display("FAIL raw_exe got valid=%0b rd=%0d imm=%0h want 1/6/55", exe_valid, exe_rd, exe_imm); end
  endtask

  task automatic test_waw_x0();
    do_reset();
    offer(0, 1, 2, 0, 1, 3, 32'h0);
    step();
    #1;
    vectors++; if (sb_valid !== 1'b1) begin errors++; $display("FAIL x0_first got %0b want 1", sb_valid); end
    step();
    dec_valid = 0;
    #1;
    vectors++; if (sb_valid !== 1'b1) begin errors++; $display("FAIL x0_second got %0b want 1", sb_valid); end
    step();
    #1;
    vectors++; if (dut.u_busy.busy[0] !== 1'b0 || exe_valid !== 1'b1) begin errors++; $display("FAIL x0_busy got busy0=%0b exe_valid=%0b want 0/1", dut.u_busy.busy[0], exe_valid); end
    offer(0, 1, 2, 7, 1, 4, 32'h0);
    step();
    offer(1, 3, 4, 7, 1, 5, 32'h77);
    step();
    dec_valid = 0;
    for (int c = 0; c < 2; c++) begin
      #1;
      vectors++; if (sb_valid !== 1'b0) begin errors++; $display("FAIL waw_stall_%0d got %0b want 0", c, sb_valid); end
      step();
    end
    wb_valid = 1; wb_rd = 7;
    step();
    wb_valid = 0;
    #1;
    vectors++; if (sb_valid !== 1'b1 || sb_dest !== 1'b1) begin errors++; $display("FAIL waw_release got sb_valid=%0b dest=%0b want 1/1", sb_valid, sb_dest); end
    step();
  endtask

  task automatic test_unit_stall();
    do_reset();
    ls_busy = 1;
    offer(1, 3, 4, 8, 1, 5, 32'hABCD);
    step();
    for (int c = 0; c < 3; c++) begin
      offer(0, $urandom_range(31), $urandom_range(31), $urandom_range(31), 1,
            $urandom_range(63), $urandom);
      #1;
      vectors++; if (sb_valid !== 1'b0 || dec_ready !== 1'b0) begin errors++; $display("FAIL ls_stall_%0d got sb_valid=%0b dec_ready=%0b want 0/0", c, sb_valid, dec_ready); end
      vectors++; if (sb_rs1 !== 5'd3 || sb_rs2 !== 5'd4 || sb_dest !== 1'b1) begin errors++; $display("FAIL ls_hold_%0d got rs=%0d/%0d dest=%0b want 3/4/1", c, sb_rs1, sb_rs2, sb_dest); end
      step();
    end
    ls_busy = 0; dec_valid = 0;
    #1;
    vectors++; if (sb_valid !== 1'b1) begin errors++; $display("FAIL ls_release got %0b want 1", sb_valid); end
    step();
    #1;
    vectors++; if (exe_op !== 6'd5 || exe_imm !== 32'hABCD || exe_dest !== 1'b1 || exe_rd !== 5'd8) begin errors++; $display("FAIL ls_exe got op=%0d imm=%0h dest=%0b rd=%0d want 5/abcd/1/8", exe_op, exe_imm, exe_dest, exe_rd); end
    ls_busy = 1;
    offer(0, 1, 2, 9, 1, 6, 32'h0);
    step();
    dec_valid = 0;
    #1;
    vectors++; if (sb_valid !== 1'b1) begin errors++; $display("FAIL alu_ignores_ls_busy got %0b want 1", sb_valid); end
    step();
    ls_busy = 0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 11; k++) begin
      if (k < 8) offer(0, 1, 2, 10 + k, 1, k, 32'(k * 3));
      else dec_valid = 0;
      #1;
      if (k < 8) begin
        vectors++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL stream_ready_%0d got %0b want 1", k, dec_ready); end
      end
      if (k >= 2 && k <= 9) begin
        vectors++; if (exe_valid !== 1'b1 || exe_rd !== 5'(8 + k) || exe_op !== 6'(k - 2)) begin errors++; $display("FAIL stream_exe_%0d got valid=%0b rd=%0d op=%0d want 1/%0d/%0d", k, exe_valid, exe_rd, exe_op, 8 + k, k - 2); end
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    offer(0, 1, 2, 4, 1, 1, 32'h0);
    step();
    offer(0, 4, 1, 11, 1, 2, 32'h0);
    step();
    dec_valid = 0;
    #1;
    vectors++; if (dut.u_busy.busy[4] !== 1'b1 || sb_valid !== 1'b0) begin errors++; $display("FAIL midrst_pre got busy4=%0b sb_valid=%0b want 1/0", dut.u_busy.busy[4], sb_valid); end
    rst = 1;
    step();
    rst = 0;
    #1;
    vectors++; if (sb_valid !== 1'b0 || exe_valid !== 1'b0 || dec_ready !== 1'b1) begin errors++; $display("FAIL midrst_post got sb=%0b exe=%0b ready=%0b want 0/0/1", sb_valid, exe_valid, dec_ready); end
    vectors++; if (dut.u_busy.busy !== 32'd0) begin errors++; $display("FAIL midrst_busy got %h want 0", dut.u_busy.busy); end
  endtask

  task automatic test_random();
    do_reset();
    m_clear();
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(79) == 0);
      dec_valid = ($urandom_range(3) != 0);
      dec_dest  = 1'($urandom_range(1));
      dec_rs1   = 5'($urandom_range(7));
      dec_rs2   = 5'($urandom_range(7));
      dec_rd    = 5'($urandom_range(7));
      dec_rd_en = 1'($urandom_range(1));
      dec_op    = 6'($urandom_range(63));
      dec_imm   = $urandom;
      alu_busy  = ($urandom_range(3) == 0);
      ls_busy   = ($urandom_range(3) == 0);
      wb_valid  = ($urandom_range(2) == 0);
      wb_rd     = 5'($urandom_range(7));
      #1;
      vectors++; if (sb_valid !== m_can_issue()) begin errors++; $display("FAIL rnd_sb_valid cyc %0d got %0b want %0b", c, sb_valid, m_can_issue()); end
      vectors++; if (dec_ready !== m_ready()) begin errors++; $display("FAIL rnd_dec_ready cyc %0d got %0b want %0b", c, dec_ready, m_ready()); end
      vectors++; if (sb_rs1 !== 5'(m_last.rs1) || sb_rs2 !== 5'(m_last.rs2) || sb_dest !== m_last.dest) begin errors++; $display("FAIL rnd_sb_fields cyc %0d got %0d/%0d/%0b want %0d/%0d/%0b", c, sb_rs1, sb_rs2, sb_dest, m_last.rs1, m_last.rs2, m_last.dest); end
      vectors++; if (exe_valid !== m_exe_valid) begin errors++; $display("FAIL rnd_exe_valid cyc %0d got %0b want %0b", c, exe_valid, m_exe_valid); end
      vectors++; if (exe_rd !== 5'(m_exe.rd) || exe_op !== 6'(m_exe.op) || exe_imm !== m_exe.imm || exe_dest !== m_exe.dest || exe_rd_en !== m_exe.rd_en) begin errors++; $display("FAIL rnd_exe_fields cyc %0d got rd=%0d op=%0d imm=%0h want rd=%0d op=%0d imm=%0h", c, exe_rd, exe_op, exe_imm, m_exe.rd, m_exe.op, m_exe.imm); end
      step();
    end
    rst = 0;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    m_clear();
    test_reset();
    test_basic_alu();
    test_raw();
    test_waw_x0();
    test_unit_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
